// File: rtl/lamp_pkg.sv
// Shared constants, fault codes and FSM state type for the lamp feedback decoder.
package lamp_pkg;

    localparam int unsigned LAMP_COUNT = 16;

    localparam logic [1:0] FAULT_OK        = 2'b00;
    localparam logic [1:0] FAULT_BUBBLE    = 2'b01;
    localparam logic [1:0] FAULT_OVERRANGE = 2'b10;

    typedef enum logic [1:0] {
        S_SETTLE,
        S_REPORT,
        S_HOLD
    } state_t;

    function automatic logic [3:0] popcount15(input logic [14:0] v);
        logic [3:0] c;
        c = '0;
        for (int unsigned i = 0; i < 15; i++) begin
            c = c + 4'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/lamp_thermo_decode.sv
// Combinational thermometer-code decoder for the lamp feedback pattern.
// LAMP_BUBBLE_CORRECT_EN: bubble patterns report popcount instead of 0.
module lamp_thermo_decode
    import lamp_pkg::*;
(
    input  logic [LAMP_COUNT-1:0] pattern,
    output logic [3:0]            count,
    output logic [1:0]            fault
);

    logic thermo;

    always_comb begin
        count  = '0;
        fault  = FAULT_OK;
        // 2^n-1 patterns are exactly those with no bit set above a clear bit
        thermo = ((pattern & (pattern + 16'd1)) == '0);
        if (pattern[LAMP_COUNT-1]) begin
            count = 4'd15;
            fault = FAULT_OVERRANGE;
        end else if (thermo) begin
            count = popcount15(pattern[14:0]);
        end else begin
            fault = FAULT_BUBBLE;
`ifdef LAMP_BUBBLE_CORRECT_EN
            count = popcount15(pattern[14:0]);
`else
            count = '0;
`endif
        end
    end

endmodule

// File: rtl/lamp_feedback_decoder.sv
// Synchronises and debounces lamp feedback, decodes the active-light count and
// reports each newly settled pattern over valid/ready. Uses LAMP_BUBBLE_CORRECT_EN.
module lamp_feedback_decoder
    import lamp_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LAMP_COUNT-1:0] lamp_feedback,
    input  logic                  count_ready,
    output logic                  count_valid,
    output logic [3:0]            active_count,
    output logic [1:0]            fault,
    output logic [7:0]            fault_cnt
);

    localparam logic [7:0] STABLE_TH = 8'(STABLE_CYCLES - 1);

    logic [LAMP_COUNT-1:0] q1, q2, last_pattern;
    logic [7:0]            stab_cnt;
    logic                  first;
    logic                  stable, q2_change, load, handshake;
    logic [3:0]            dec_count;
    logic [1:0]            dec_fault;
    state_t                state, state_next;

    assign q2_change = (q1 != q2);
    assign stable    = (stab_cnt >= STABLE_TH);

    lamp_thermo_decode u_decode (
        .pattern (q2),
        .count   (dec_count),
        .fault   (dec_fault)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q1       <= '0;
            q2       <= '0;
            stab_cnt <= '0;
        end else begin
            q1 <= lamp_feedback;
            q2 <= q1;
            if (q2_change) begin
                stab_cnt <= '0;
            end else if (stab_cnt != 8'hFF) begin
                stab_cnt <= stab_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        handshake  = 1'b0;
        case (state)
            S_SETTLE: begin
                if (stable && (first || q2 != last_pattern)) begin
                    load       = 1'b1;
                    state_next = S_REPORT;
                end else if (stable) begin
                    state_next = S_HOLD;
                end
            end
            S_REPORT: begin
                if (count_ready) begin
                    handshake  = 1'b1;
                    state_next = (stable && q2 == last_pattern) ? S_HOLD : S_SETTLE;
                end
            end
            S_HOLD: begin
                // also leave if q2 moved on the very edge HOLD was entered
                if (q2_change || q2 != last_pattern) begin
                    state_next = S_SETTLE;
                end
            end
            default: state_next = S_SETTLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_SETTLE;
            count_valid  <= 1'b0;
            active_count <= '0;
            fault        <= FAULT_OK;
            fault_cnt    <= '0;
            last_pattern <= '0;
            first        <= 1'b1;
        end else begin
            state <= state_next;
            if (load) begin
                active_count <= dec_count;
                fault        <= dec_fault;
                last_pattern <= q2;
                first        <= 1'b0;
                count_valid  <= 1'b1;
            end
            if (handshake) begin
                count_valid <= 1'b0;
                if (fault != FAULT_OK && fault_cnt != 8'hFF) begin
                    fault_cnt <= fault_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: doc/lamp_feedback_decoder.md
# lamp_feedback_decoder

Reverse path of the lamp driver: samples the 16-bit lamp-feedback bus coming back from the lamp sensors and recovers the active-light count (0..15) that produced it. It synchronises the asynchronous feedback, filters glitches with a stability counter, decodes the thermometer code, classifies faults, and presents one result per settled pattern over a valid/ready handshake. It sits between the lamp sensor inputs and the controller's supervision logic.

## Interface
- STABLE_CYCLES, 4: consecutive synchronised samples required before a pattern is accepted; legal range 1..255.
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- lamp_feedback  input  16  raw lamp-on sensor bits, asynchronous to clk; bit i is lamp i.
- count_ready  input  1  consumer accepts the presented result.
- count_valid  output  1  result presented.
- active_count  output  4  decoded number of lit lamps.
- fault  output  2  00 ok, 01 bubble (non-thermometer), 10 overrange (bit 15 set).
- fault_cnt  output  8  saturating count of accepted results with fault != 00.

## Operation
- Two-flop synchroniser q1→q2 on lamp_feedback; both reset to 0.
- stab_cnt: cleared to 0 on any edge where q2 loads a value different from its current value; otherwise increments, saturating at 255. stable = (stab_cnt >= STABLE_CYCLES-1).
- Decode of q2, priority order: bit 15 set → count 15, fault 10; q2 == 2^n-1 (n = 0..15) → count n, fault 00; else bubble → count 0, fault 01.
- last_pattern register and first flag: first = 1 after reset, so the first stable pattern (including all-zero) is always reported.
- FSM states:
  - S_SETTLE: if stable and (first or q2 != last_pattern) → load active_count/fault from decode, last_pattern <= q2, first <= 0, count_valid <= 1, go S_REPORT. If stable and q2 == last_pattern → S_HOLD.
  - S_REPORT: outputs frozen while count_ready = 0, regardless of input activity. On count_ready = 1: count_valid <= 0; fault_cnt += 1 (saturate at 255) if fault != 00; go S_HOLD if stable and q2 == last_pattern, else S_SETTLE.
  - S_HOLD: on stab_cnt clear (q2 changed) → S_SETTLE.
- Patterns that change before stabilising, or that stabilise and change again while in S_REPORT, are never reported; only the pattern stable when the slot frees is reported.
- A pattern that returns to last_pattern after a glitch is not re-reported.
- Reset: count_valid 0, active_count 0, fault 00, fault_cnt 0, stab_cnt 0, last_pattern 0, first 1, state S_SETTLE.

## Timing
- Latency: input held at P from edge 0 with FSM in S_SETTLE/S_HOLD → q2 = P after edge 2 → count_valid high after edge 2+STABLE_CYCLES.
- Out of reset with input 0: count_valid high after edge STABLE_CYCLES (q2 already equals input), count 0.
- Handshake completes on any edge where count_valid and count_ready are both 1; next result earliest one cycle later (no back-to-back valid).
- count_ready while count_valid = 0 is ignored.
- Reset asserted mid-REPORT clears outputs immediately without waiting for an edge.

## Configuration
- LAMP_BUBBLE_CORRECT_EN defined: bubble patterns report active_count = popcount(q2[14:0]) (max 15), fault still 01, still counted in fault_cnt.
- Not defined: bubble patterns report active_count = 0, fault 01. Overrange and ok paths identical in both builds.

## Structure
- Package lamp_pkg: LAMP_COUNT = 16, fault code constants FAULT_OK/FAULT_BUBBLE/FAULT_OVERRANGE, FSM state typedef (S_SETTLE, S_REPORT, S_HOLD).
- One combinational sub-module lamp_thermo_decode: 16-bit pattern in, 4-bit count and 2-bit fault out, holds the macro-dependent bubble path.
- Top holds synchroniser, stab_cnt, FSM, output and fault_cnt registers.

## Test plan
- Reset, lamp_feedback = 0x0007 held, count_ready = 1, STABLE_CYCLES = 4 → count_valid single-cycle pulse after edge 6, active_count 3, fault 00.
- count_ready = 0 with 0x0007 reported, then input → 0x00FF → outputs held at 3 until ready; after handshake, next report active_count 8 one cycle later.
- Glitch: 0x0001 settled and reported, then 0x0003 for 2 cycles, back to 0x0001 → no further count_valid.
- 0x0005 held → fault 01, active_count 0 (macro off) or 2 (macro on); fault_cnt 0 → 1 on handshake.
- 0xFFFF held → active_count 15, fault 10; 300 such faulting reports → fault_cnt saturates at 255.
- rst pulsed while in S_REPORT → count_valid/active_count/fault_cnt 0 immediately; after release current pattern re-reported per latency rule.
